// File: rtl/axis_hdr_pkg.sv
// -----------------------------------------------------------------------------
// axis_hdr_pkg
// Shared definitions for the AXI-Stream header source:
//   hdr_mode_e    - byte-count generation mode (FIXED / INCR / RANDOM)
//   hdr_state_e   - generator FSM states
//   LFSR_MASK     - Galois feedback mask of the 32-bit LFSR
//   keep_from_cnt - right-aligned byte-enable mask for a byte count n
//   decode_mode   - maps the 2-bit mode input onto hdr_mode_e (2 and 3 = RANDOM)
// -----------------------------------------------------------------------------
package axis_hdr_pkg;

    typedef enum logic [1:0] {
        HDR_FIXED  = 2'd0,
        HDR_INCR   = 2'd1,
        HDR_RANDOM = 2'd2
    } hdr_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } hdr_state_e;

    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    // Widest supported bus is 512 bits = 64 bytes; callers keep the low bits.
    localparam int MAX_BYTES = 64;

    function automatic logic [MAX_BYTES-1:0] keep_from_cnt(input logic [7:0] n);
        logic [MAX_BYTES-1:0] k;
        k = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            k[i] = (i < int'(n));
        end
        return k;
    endfunction

    function automatic hdr_mode_e decode_mode(input logic [1:0] m);
        hdr_mode_e r;
        case (m)
            2'd0:    r = HDR_FIXED;
            2'd1:    r = HDR_INCR;
            default: r = HDR_RANDOM;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/axis_hdr_lfsr32.sv
// -----------------------------------------------------------------------------
// axis_hdr_lfsr32
// 32-bit Galois LFSR (mask LFSR_MASK, shifting right) that advances only when
// step is high. A zero SEED would lock the register at zero, so it is
// replaced by 1.
// Ports:
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset, loads the seed
//   step      in   advance one position this cycle
//   lfsr      out  current register value
//   lfsr_next out  value the register takes on the next step
// -----------------------------------------------------------------------------
module axis_hdr_lfsr32
    import axis_hdr_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_1234
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step,
    output logic [31:0] lfsr,
    output logic [31:0] lfsr_next
);

    localparam logic [31:0] SEED_SAFE = (SEED == 32'd0) ? 32'd1 : SEED;

    assign lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_MASK : 32'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= SEED_SAFE;
        end else if (step) begin
            lfsr <= lfsr_next;
        end
    end

endmodule

// File: rtl/axis_header_src_gen.sv
// -----------------------------------------------------------------------------
// axis_header_src_gen
// AXI-Stream header source for the header-insert path. Produces header beats
// with right-aligned keep and a matching byte count, in FIXED, INCR or RANDOM
// count mode, driven by a deterministic LFSR that steps once per handshake.
//
// Optional build macro AXIS_HDR_THROTTLE_EN: after each non-final handshake
// insert lfsr[31:30] idle cycles (GAP state) before the next beat.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   cfg_en               run enable
//   cfg_mode             0=FIXED, 1=INCR, 2/3=RANDOM (latched at run start)
//   cfg_fixed_cnt        byte count for FIXED mode (0 or oversize -> full beat)
//   cfg_num_hdr          headers per run, 0 = unbounded
//   ins_valid_m          header beat valid
//   ins_data_m           header data, bytes outside keep driven to zero
//   ins_keep_m           right-aligned byte enables
//   ins_byte_insert_cnt  number of valid bytes, 1..DATA_BYTE_WD
//   ins_ready_m          sink ready
//   done                 run complete, held until cfg_en drops
//   hdr_count            headers accepted in the current run (saturating)
// -----------------------------------------------------------------------------
module axis_header_src_gen
    import axis_hdr_pkg::*;
#(
    parameter int          DATA_WD      = 32,
    parameter int          DATA_BYTE_WD = DATA_WD / 8,
    parameter int          BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
    parameter logic [31:0] LFSR_SEED    = 32'hACE1_1234
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_en,
    input  logic [1:0]              cfg_mode,
    input  logic [BYTE_CNT_WD:0]    cfg_fixed_cnt,
    input  logic [15:0]             cfg_num_hdr,
    output logic                    ins_valid_m,
    output logic [DATA_WD-1:0]      ins_data_m,
    output logic [DATA_BYTE_WD-1:0] ins_keep_m,
    output logic [BYTE_CNT_WD:0]    ins_byte_insert_cnt,
    input  logic                    ins_ready_m,
    output logic                    done,
    output logic [15:0]             hdr_count
);

    localparam logic [BYTE_CNT_WD:0] FULL_CNT = (BYTE_CNT_WD+1)'(DATA_BYTE_WD);
    localparam logic [BYTE_CNT_WD:0] ONE_CNT  = (BYTE_CNT_WD+1)'(1);

    hdr_state_e           state;
    hdr_mode_e            mode_q;
    logic [BYTE_CNT_WD:0] fixed_q;
    logic [15:0]          num_q;
    logic [BYTE_CNT_WD:0] incr_q;
`ifdef AXIS_HDR_THROTTLE_EN
    logic [1:0]           gap_q;
`endif

    logic        hs;
    logic [31:0] lfsr;
    logic [31:0] lfsr_next;
    logic [15:0] hdr_inc;

    assign hs      = ins_valid_m && ins_ready_m;
    assign hdr_inc = (&hdr_count) ? hdr_count : hdr_count + 16'd1;

    axis_hdr_lfsr32 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk       (clk),
        .rst_n     (rst_n),
        .step      (hs),
        .lfsr      (lfsr),
        .lfsr_next (lfsr_next)
    );

    // Next-beat generation. The source operands depend on where the load
    // happens: at run start (IDLE) the live config and a zero header count
    // are used; on a handshake (SEND) the post-step LFSR and incremented
    // count are used; after a gap both have already been registered.
    hdr_mode_e                src_mode;
    logic [BYTE_CNT_WD:0]     src_fixed;
    logic [31:0]              src_lfsr;
    logic [15:0]              src_hdr;
    logic [BYTE_CNT_WD:0]     src_incr;
    logic [BYTE_CNT_WD:0]     beat_cnt;
    logic [MAX_BYTES-1:0]     keep_full;
    logic [DATA_BYTE_WD-1:0]  beat_keep;
    logic [DATA_WD-1:0]       beat_data;
    logic [7:0]               byte_val;

    always_comb begin
        src_mode  = mode_q;
        src_fixed = fixed_q;
        src_lfsr  = lfsr;
        src_hdr   = hdr_count;
        src_incr  = (incr_q == FULL_CNT) ? ONE_CNT : incr_q + ONE_CNT;
        beat_cnt  = FULL_CNT;
        keep_full = '0;
        beat_keep = '0;
        beat_data = '0;
        byte_val  = '0;

        if (state == IDLE) begin
            src_mode  = decode_mode(cfg_mode);
            src_fixed = cfg_fixed_cnt;
            src_hdr   = 16'd0;
            src_incr  = ONE_CNT;
        end else if (state == SEND) begin
            src_lfsr  = lfsr_next;
            src_hdr   = hdr_inc;
        end

        case (src_mode)
            HDR_FIXED:  beat_cnt = (src_fixed == '0 || src_fixed > FULL_CNT) ? FULL_CNT : src_fixed;
            HDR_INCR:   beat_cnt = src_incr;
            default:    beat_cnt = {1'b0, src_lfsr[BYTE_CNT_WD-1:0]} + ONE_CNT;
        endcase

        keep_full = keep_from_cnt(8'(beat_cnt));
        beat_keep = keep_full[DATA_BYTE_WD-1:0];

        // LFSR word repeats every 4 bytes; INCR fills every byte with the count.
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            byte_val = (src_mode == HDR_INCR) ? src_hdr[7:0] : src_lfsr[8*(i%4) +: 8];
            beat_data[8*i +: 8] = beat_keep[i] ? byte_val : 8'h00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            mode_q              <= HDR_FIXED;
            fixed_q             <= '0;
            num_q               <= '0;
            incr_q              <= '0;
`ifdef AXIS_HDR_THROTTLE_EN
            gap_q               <= '0;
`endif
            ins_valid_m         <= 1'b0;
            ins_data_m          <= '0;
            ins_keep_m          <= '0;
            ins_byte_insert_cnt <= '0;
            done                <= 1'b0;
            hdr_count           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (cfg_en) begin
                        mode_q              <= src_mode;
                        fixed_q             <= cfg_fixed_cnt;
                        num_q               <= cfg_num_hdr;
                        hdr_count           <= '0;
                        incr_q              <= src_incr;
                        ins_data_m          <= beat_data;
                        ins_keep_m          <= beat_keep;
                        ins_byte_insert_cnt <= beat_cnt;
                        ins_valid_m         <= 1'b1;
                        state               <= SEND;
                    end
                end

                SEND: begin
                    if (hs) begin
                        hdr_count <= hdr_inc;
                        if (num_q != 16'd0 && hdr_inc == num_q) begin
                            ins_valid_m         <= 1'b0;
                            ins_data_m          <= '0;
                            ins_keep_m          <= '0;
                            ins_byte_insert_cnt <= '0;
                            done                <= 1'b1;
                            state               <= DONE;
                        end else if (!cfg_en) begin
                            ins_valid_m         <= 1'b0;
                            ins_data_m          <= '0;
                            ins_keep_m          <= '0;
                            ins_byte_insert_cnt <= '0;
                            state               <= IDLE;
`ifdef AXIS_HDR_THROTTLE_EN
                        end else if (lfsr_next[31:30] != 2'd0) begin
                            ins_valid_m         <= 1'b0;
                            ins_data_m          <= '0;
                            ins_keep_m          <= '0;
                            ins_byte_insert_cnt <= '0;
                            gap_q               <= lfsr_next[31:30];
                            state               <= GAP;
`endif
                        end else begin
                            incr_q              <= src_incr;
                            ins_data_m          <= beat_data;
                            ins_keep_m          <= beat_keep;
                            ins_byte_insert_cnt <= beat_cnt;
                        end
                    end
                end

`ifdef AXIS_HDR_THROTTLE_EN
                GAP: begin
                    if (!cfg_en) begin
                        state <= IDLE;
                    end else if (gap_q == 2'd1) begin
                        incr_q              <= src_incr;
                        ins_data_m          <= beat_data;
                        ins_keep_m          <= beat_keep;
                        ins_byte_insert_cnt <= beat_cnt;
                        ins_valid_m         <= 1'b1;
                        state               <= SEND;
                    end else begin
                        gap_q <= gap_q - 2'd1;
                    end
                end
`endif

                DONE: begin
                    if (!cfg_en) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_header_src_gen.sv
// -----------------------------------------------------------------------------
// tb_axis_header_src_gen
// Directed bench for axis_header_src_gen (DATA_WD=32). Expected beats are
// pushed to a scoreboard queue when a run is configured and popped by the
// monitor on every handshake. A golden LFSR model recomputes the sequence
// from the seed. Build with AXIS_HDR_THROTTLE_EN to also check idle gaps.
// -----------------------------------------------------------------------------
module tb_axis_header_src_gen;

    localparam int          DW   = 32;
    localparam int          DBW  = 4;
    localparam int          CW   = 2;
    localparam logic [31:0] SEED = 32'hACE1_1234;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           cfg_en = 1'b0;
    logic [1:0]     cfg_mode = 2'd0;
    logic [CW:0]    cfg_fixed_cnt = '0;
    logic [15:0]    cfg_num_hdr = '0;
    logic           ins_valid_m;
    logic [DW-1:0]  ins_data_m;
    logic [DBW-1:0] ins_keep_m;
    logic [CW:0]    ins_byte_insert_cnt;
    logic           ins_ready_m = 1'b0;
    logic           done;
    logic [15:0]    hdr_count;

    always #5 clk = ~clk;

    axis_header_src_gen dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .cfg_en              (cfg_en),
        .cfg_mode            (cfg_mode),
        .cfg_fixed_cnt       (cfg_fixed_cnt),
        .cfg_num_hdr         (cfg_num_hdr),
        .ins_valid_m         (ins_valid_m),
        .ins_data_m          (ins_data_m),
        .ins_keep_m          (ins_keep_m),
        .ins_byte_insert_cnt (ins_byte_insert_cnt),
        .ins_ready_m         (ins_ready_m),
        .done                (done),
        .hdr_count           (hdr_count)
    );

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic [2:0]  cnt;
        int          gap;
        bit          chk_gap;
    } beat_t;

    beat_t sb[$];
    int    checks   = 0;
    int    errors   = 0;
    int    pops     = 0;
    int    total_hs = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] golden_step(input logic [31:0] x);
        logic        lsb;
        logic [31:0] y;
        lsb = x[0];
        y   = x >> 1;
        if (lsb) y = y ^ 32'h8020_0003;
        return y;
    endfunction

    function automatic logic [31:0] lfsr_after(input int n);
        logic [31:0] x;
        x = SEED;
        for (int i = 0; i < n; i++) x = golden_step(x);
        return x;
    endfunction

    // Expected beat k of a run; lf is the LFSR after base+k handshakes, which
    // is both the word used by beat k and the one that set the gap before it.
    function automatic beat_t model(input int mode, input int fixed, input int k,
                                    input logic [31:0] lf);
        beat_t      b;
        int         n;
        logic [7:0] v;
        logic [7:0] kb;
        if (mode == 0)      n = (fixed == 0 || fixed > DBW) ? DBW : fixed;
        else if (mode == 1) n = (k % DBW) + 1;
        else                n = int'(lf[1:0]) + 1;
        kb     = 8'(k);
        b.cnt  = 3'(n);
        b.keep = '0;
        b.data = '0;
        for (int i = 0; i < DBW; i++) begin
            v = (mode == 1) ? kb : lf[8*i +: 8];
            if (i < n) begin
                b.keep[i]       = 1'b1;
                b.data[8*i +: 8] = v;
            end
        end
`ifdef AXIS_HDR_THROTTLE_EN
        b.gap = int'(lf[31:30]);
`else
        b.gap = 0;
`endif
        b.chk_gap = (k > 0);
        return b;
    endfunction

    task automatic push_run(input int mode, input int fixed, input int nbeats);
        for (int k = 0; k < nbeats; k++) begin
            sb.push_back(model(mode, fixed, k, lfsr_after(total_hs + k)));
        end
        total_hs += nbeats;
    endtask

    task automatic start_run(input int mode, input int fixed, input int num);
        @(posedge clk); #1;
        cfg_mode      = 2'(mode);
        cfg_fixed_cnt = 3'(fixed);
        cfg_num_hdr   = 16'(num);
        cfg_en        = 1'b1;
        @(posedge clk); #1;
        chk("start_latency_valid", 64'(ins_valid_m), 64'd1);
    endtask

    task automatic wait_pops(input int target, input int budget, input string tag);
        int c;
        c = 0;
        while (pops < target && c < budget) begin
            @(posedge clk); #1;
            c++;
        end
        chk(tag, 64'(pops), 64'(target));
    endtask

    task automatic stop_run();
        cfg_en = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("stop_done_cleared", 64'(done), 64'd0);
        chk("stop_valid_low", 64'(ins_valid_m), 64'd0);
    endtask

    // Monitor: protocol hold check plus scoreboard compare on each handshake.
    logic           prev_v = 1'b0;
    logic           prev_r = 1'b0;
    logic [DW-1:0]  prev_d = '0;
    logic [DBW-1:0] prev_k = '0;
    logic [CW:0]    prev_c = '0;
    int             idle_run = 0;

    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            prev_v   = 1'b0;
            prev_r   = 1'b0;
            idle_run = 0;
        end else begin
            if (prev_v && !prev_r) begin
                chk("hold_valid", 64'(ins_valid_m), 64'd1);
                chk("hold_data", 64'(ins_data_m), 64'(prev_d));
                chk("hold_keep", 64'(ins_keep_m), 64'(prev_k));
                chk("hold_cnt", 64'(ins_byte_insert_cnt), 64'(prev_c));
            end
            if (ins_valid_m && ins_ready_m) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 64'(ins_data_m), 64'hDEAD_0000_0000);
                end else begin
                    e = sb.pop_front();
                    chk("beat_data", 64'(ins_data_m), 64'(e.data));
                    chk("beat_keep", 64'(ins_keep_m), 64'(e.keep));
                    chk("beat_cnt", 64'(ins_byte_insert_cnt), 64'(e.cnt));
                    if (e.chk_gap) chk("beat_gap", 64'(idle_run), 64'(e.gap));
                end
                pops++;
                idle_run = 0;
            end else if (!ins_valid_m) begin
                idle_run++;
            end
            prev_v = ins_valid_m;
            prev_r = ins_ready_m;
            prev_d = ins_data_m;
            prev_k = ins_keep_m;
            prev_c = ins_byte_insert_cnt;
        end
    end

    initial begin
        int p0;
        int c;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(ins_valid_m), 64'd0);
        chk("rst_data", 64'(ins_data_m), 64'd0);
        chk("rst_keep", 64'(ins_keep_m), 64'd0);
        chk("rst_cnt", 64'(ins_byte_insert_cnt), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hdr_count", 64'(hdr_count), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // FIXED, count 3, four headers, sink always ready
        ins_ready_m = 1'b1;
        push_run(0, 3, 4);
        start_run(0, 3, 4);
        wait_pops(4, 60, "fixed3_beats");
        chk("fixed3_done", 64'(done), 64'd1);
        chk("fixed3_hdr_count", 64'(hdr_count), 64'd4);
        chk("fixed3_valid_low", 64'(ins_valid_m), 64'd0);
        stop_run();
        chk("fixed3_count_held", 64'(hdr_count), 64'd4);

        // INCR, six headers
        push_run(1, 0, 6);
        start_run(1, 0, 6);
        wait_pops(10, 80, "incr_beats");
        chk("incr_done", 64'(done), 64'd1);
        chk("incr_hdr_count", 64'(hdr_count), 64'd6);
        stop_run();

        // FIXED clamp: 0 and 7 both give a full beat
        push_run(0, 0, 2);
        start_run(0, 0, 2);
        wait_pops(12, 60, "fixed0_beats");
        chk("fixed0_done", 64'(done), 64'd1);
        stop_run();
        push_run(0, 7, 2);
        start_run(0, 7, 2);
        wait_pops(14, 60, "fixed7_beats");
        chk("fixed7_done", 64'(done), 64'd1);
        stop_run();

        // RANDOM, unbounded, ready toggling; then drop enable on a held beat
        p0 = pops;
        push_run(2, 0, 21);
        start_run(2, 0, 0);
        c = 0;
        while (pops < p0 + 20 && c < 600) begin
            @(posedge clk); #1;
            if (pops < p0 + 20) ins_ready_m = ~ins_ready_m;
            c++;
        end
        chk("random_twenty", 64'(pops), 64'(p0 + 20));
        ins_ready_m = 1'b0;
        c = 0;
        while (!ins_valid_m && c < 20) begin
            @(posedge clk); #1;
            c++;
        end
        chk("held_valid_before_drop", 64'(ins_valid_m), 64'd1);
        cfg_en = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("held_valid_after_drop", 64'(ins_valid_m), 64'd1);
        ins_ready_m = 1'b1;
        wait_pops(p0 + 21, 20, "held_beat_completes");
        chk("idle_after_drop", 64'(ins_valid_m), 64'd0);
        @(posedge clk); #1;
        chk("idle_stays_low", 64'(ins_valid_m), 64'd0);
        chk("idle_no_done", 64'(done), 64'd0);

        // Reset mid-run while a beat is held
        ins_ready_m = 1'b0;
        start_run(0, 2, 0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(ins_valid_m), 64'd0);
        chk("midrst_data", 64'(ins_data_m), 64'd0);
        chk("midrst_keep", 64'(ins_keep_m), 64'd0);
        chk("midrst_cnt", 64'(ins_byte_insert_cnt), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_hdr_count", 64'(hdr_count), 64'd0);
        cfg_en = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        total_hs = 0;
        sb.delete();

        // LFSR reseeded: RANDOM run restarts from the seed sequence
        p0 = pops;
        ins_ready_m = 1'b1;
        push_run(2, 0, 3);
        start_run(2, 0, 3);
        wait_pops(p0 + 3, 60, "reseed_beats");
        chk("reseed_done", 64'(done), 64'd1);
        stop_run();

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
